// File: rtl/gpc_6_3_if.sv
// Operand/result bundle for the 6:3 GPC leaf cell.
// The producer side uses master and the counter cell uses slave.
interface gpc_6_3_if;
    logic       in_valid;
    logic [5:0] src0;
    logic [2:0] dst;
    logic       out_valid;

    modport master (
        output in_valid,
        output src0,
        input  dst,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  src0,
        output dst,
        output out_valid
    );
endinterface

// File: rtl/gpc_6_3.sv
// Registered 6:3 generalized parallel counter: dst = number of ones in src0.
// This cell is one pipeline stage of a compressor tree.
module gpc_6_3 (
    input  logic      clk,
    input  logic      rst,
    gpc_6_3_if.slave  bus
);
    logic       sa, ca, sb, cb, k;
    logic [2:0] count;
    logic [2:0] dst_q;
    logic       valid_q;

    // Two full adders reduce the six bits to one weight-1 sum pair and three weight-2 carries
    always_comb begin
        sa    = bus.src0[0] ^ bus.src0[1] ^ bus.src0[2];
        ca    = (bus.src0[0] & bus.src0[1]) | (bus.src0[0] & bus.src0[2]) | (bus.src0[1] & bus.src0[2]);
        sb    = bus.src0[3] ^ bus.src0[4] ^ bus.src0[5];
        cb    = (bus.src0[3] & bus.src0[4]) | (bus.src0[3] & bus.src0[5]) | (bus.src0[4] & bus.src0[5]);
        k     = sa & sb;
        count = {(ca & cb) | (ca & k) | (cb & k), ca ^ cb ^ k, sa ^ sb};
    end

    // dst only loads on valid input, so idle cycles leave it unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid)
                dst_q <= count;
        end
    end

    assign bus.dst       = dst_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_gpc_6_3.sv
// Self-checking bench for gpc_6_3: popcount model with per-cycle compare,
// directed literal expectations, exhaustive sweep and randomized traffic.
module tb_gpc_6_3;
    logic clk = 1'b0;
    logic rst = 1'b0;
    gpc_6_3_if bus ();

    gpc_6_3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the outputs must show after each rising edge
    bit model_known = 1'b0;
    int model_dst   = 0;
    bit model_valid = 1'b0;

    function automatic int ones(input logic [5:0] s);
        int n = 0;
        for (int i = 0; i < 6; i++)
            n += int'(s[i]);
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_known = 1'b1;
            model_dst   = 0;
            model_valid = 1'b0;
        end else if (model_known) begin
            model_valid = bus.in_valid;
            if (bus.in_valid)
                model_dst = ones(bus.src0);
        end
    end

    // Outputs only change on rising edges, so the falling edge is a quiet sampling point
    always @(negedge clk) begin
        if (model_known) begin
            check("model_dst", int'(bus.dst), model_dst);
            check("model_out_valid", int'(bus.out_valid), int'(model_valid));
        end
    end

    task automatic apply(input logic r, input logic v, input logic [5:0] s);
        @(negedge clk);
        rst          = r;
        bus.in_valid = v;
        bus.src0     = s;
    endtask

    // Called right after apply(): shows the result of the input applied one step earlier
    task automatic lit(input string name, input int d, input int ov);
        check({name, "_dst"}, int'(bus.dst), d);
        check({name, "_out_valid"}, int'(bus.out_valid), ov);
    endtask

    localparam int NDIR = 28;
    localparam logic [5:0] DIR_SRC [NDIR] = '{
        6'h12, 6'h31, 6'h20, 6'h2e, 6'h1a, 6'h3f, 6'h0e, 6'h15, 6'h25, 6'h39,
        6'h26, 6'h38, 6'h1e, 6'h23, 6'h29, 6'h2d, 6'h13, 6'h3d,
        6'h00, 6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h3f, 6'h3e, 6'h1f
    };
    localparam int DIR_EXP [NDIR] = '{
        2, 3, 1, 4, 3, 6, 3, 3, 3, 4, 3, 3, 4, 3, 3, 4, 3, 5,
        0, 1, 1, 1, 1, 1, 1, 6, 5, 5
    };

    int captured [64];
    int total;

    initial begin
        bus.in_valid = 1'b0;
        bus.src0     = '0;

        // Reset with a live all-ones input that must be discarded
        apply(1'b1, 1'b1, 6'h3f);
        apply(1'b1, 1'b1, 6'h3f);
        lit("reset0", 0, 0);
        apply(1'b0, 1'b1, 6'h3f);
        lit("reset1", 0, 0);
        apply(1'b0, 1'b0, 6'h00);
        lit("post_reset", 6, 1);

        // Directed values and boundaries, back-to-back
        for (int i = 0; i < NDIR; i++) begin
            apply(1'b0, 1'b1, DIR_SRC[i]);
            if (i > 0)
                lit("directed", DIR_EXP[i - 1], 1);
        end
        apply(1'b0, 1'b0, 6'h00);
        lit("directed_last", DIR_EXP[NDIR - 1], 1);

        // Hold: idle cycles keep dst and drop out_valid
        apply(1'b0, 1'b1, 6'h2e);
        apply(1'b0, 1'b0, 6'h3f);
        lit("hold_load", 4, 1);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 6'h3f);
            lit("hold_idle", 4, 0);
        end

        // Exhaustive sweep with no bubbles
        for (int i = 0; i < 64; i++) begin
            apply(1'b0, 1'b1, 6'(i));
            if (i > 0)
                captured[i - 1] = int'(bus.dst);
        end
        apply(1'b0, 1'b0, 6'h00);
        captured[63] = int'(bus.dst);
        check("sweep_first", captured[0], 0);
        check("sweep_last", captured[63], 6);
        total = 0;
        for (int i = 0; i < 64; i++)
            total += captured[i];
        check("sweep_total", total, 192);
        for (int i = 0; i < 64; i += 2)
            check("sweep_pair", captured[i] + captured[i + 1], ones(6'(i)) + ones(6'(i + 1)));

        // Reset mid-stream
        apply(1'b0, 1'b1, 6'h15);
        apply(1'b1, 1'b1, 6'h3f);
        lit("mid_before", 3, 1);
        apply(1'b0, 1'b1, 6'h3d);
        lit("mid_reset", 0, 0);
        apply(1'b0, 1'b0, 6'h00);
        lit("mid_after", 5, 1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 500; i++)
            apply(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
        apply(1'b0, 1'b0, 6'h00);
        apply(1'b0, 1'b0, 6'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end
endmodule
